// File: rtl/mod_exp_if.sv
// mod_exp_if: start/operand/result handshake bundle between a requester and the mod_exp engine
interface mod_exp_if #(parameter int WIDTH = 16);
   logic ready_in;
   logic [WIDTH-1:0] base_in;
   logic [WIDTH-1:0] exponent_in;
   logic [WIDTH-1:0] modulus_in;
   logic [WIDTH-1:0] result_out;
   logic busy_out;
   logic valid_out;
   logic error_out;
   modport master (output ready_in, base_in, exponent_in, modulus_in,
                   input result_out, busy_out, valid_out, error_out);
   modport slave (input ready_in, base_in, exponent_in, modulus_in,
                  output result_out, busy_out, valid_out, error_out);
endinterface

// File: rtl/mod_exp.sv
// mod_exp: base^exponent mod modulus, MSB-first square-and-multiply over a bit-serial interleaved modular multiplier; MOD_EXP_CONSTANT_TIME_EN forces a multiply for every exponent bit
module mod_exp #(parameter int WIDTH = 16) (
   input logic clk_in,
   input logic rst_in,
   mod_exp_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);
   typedef enum logic [2:0] {IDLE, REDUCE, SQR, MUL, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] base, expo, modulus, acc, b_red, result, a_op, b_op;
   logic [WIDTH+1:0] p, s0, s1, s2, m_ext, addend;
   logic [CW-1:0] cnt, idx;
   logic err, busy, valid, error, last, take;
   assign bus.result_out = result;
   assign bus.busy_out = busy;
   assign bus.valid_out = valid;
   assign bus.error_out = error;
   // one multiplier bit step: shift-add, then at most two conditional subtractions keep P below m
   always_comb begin
      a_op = state == REDUCE ? base : acc;
      b_op = state == REDUCE ? WIDTH'(1) : state == SQR ? acc : b_red;
      m_ext = {2'b00, modulus};
      addend = a_op[cnt] ? {2'b00, b_op} : '0;
      s0 = (p << 1) + addend;
      s1 = s0 >= m_ext ? s0 - m_ext : s0;
      s2 = s1 >= m_ext ? s1 - m_ext : s1;
      last = idx == '0;
      take = expo[idx];
   end
   // control sequence and datapath registers; every compute state spends WIDTH cycles per multiply
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
         base <= '0;
         expo <= '0;
         modulus <= '0;
         acc <= '0;
         b_red <= '0;
         result <= '0;
         p <= '0;
         cnt <= '0;
         idx <= '0;
         err <= 1'b0;
         busy <= 1'b0;
         valid <= 1'b0;
         error <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               error <= 1'b0;
               if (bus.ready_in) begin
                  base <= bus.base_in;
                  expo <= bus.exponent_in;
                  modulus <= bus.modulus_in;
                  busy <= 1'b1;
                  err <= bus.modulus_in == '0;
                  p <= '0;
                  cnt <= TOP;
                  state <= bus.modulus_in == '0 ? DONE : REDUCE;
               end
            end
            REDUCE, SQR, MUL: begin
               p <= cnt == '0 ? '0 : s2;
               cnt <= cnt == '0 ? TOP : cnt - 1'b1;
               if (cnt == '0) begin
                  if (state == REDUCE) begin
                     b_red <= s2[WIDTH-1:0];
                     acc <= modulus == WIDTH'(1) ? '0 : WIDTH'(1);
                     idx <= TOP;
                     state <= SQR;
                  end else if (state == SQR) begin
                     acc <= s2[WIDTH-1:0];
`ifdef MOD_EXP_CONSTANT_TIME_EN
                     state <= MUL;
`else
                     if (take) state <= MUL;
                     else begin
                        idx <= idx - 1'b1;
                        state <= last ? DONE : SQR;
                     end
`endif
                  end else begin
                     if (take) acc <= s2[WIDTH-1:0];
                     idx <= idx - 1'b1;
                     state <= last ? DONE : SQR;
                  end
               end
            end
            default: begin
               result <= err ? '0 : acc;
               valid <= 1'b1;
               error <= err;
               busy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mod_exp.sv
// tb_mod_exp: randomized and directed checks of mod_exp at WIDTH 16 and 8 against a right-to-left exponentiation model
module tb_mod_exp;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int passed = 0;
   int total = 0;
   always #5 clk = ~clk;
   mod_exp_if #(16) b16 ();
   mod_exp_if #(8) b8 ();
   mod_exp #(.WIDTH(16)) dut16 (.clk_in(clk), .rst_in(rst), .bus(b16.slave));
   mod_exp #(.WIDTH(8)) dut8 (.clk_in(clk), .rst_in(rst), .bus(b8.slave));

   function automatic logic [15:0] ref_exp(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
      longint r, x;
      if (m == 0) return 16'd0;
      r = 1 % longint'(m);
      x = longint'(b) % longint'(m);
      for (int i = 0; i < 16; i++) begin
         if (e[i]) r = (r * x) % longint'(m);
         x = (x * x) % longint'(m);
      end
      return 16'(r);
   endfunction

   function automatic int lat(input int w, input logic [15:0] e, input logic [15:0] m);
      if (m == 0) return 0;
`ifdef MOD_EXP_CONSTANT_TIME_EN
      return w * (1 + 2 * w);
`else
      return w * (1 + w + $countones(e));
`endif
   endfunction

   function automatic logic [15:0] res(input bit w8);
      return w8 ? {8'h00, b8.result_out} : b16.result_out;
   endfunction
   function automatic logic bsy(input bit w8);
      return w8 ? b8.busy_out : b16.busy_out;
   endfunction
   function automatic logic vld(input bit w8);
      return w8 ? b8.valid_out : b16.valid_out;
   endfunction
   function automatic logic erro(input bit w8);
      return w8 ? b8.error_out : b16.error_out;
   endfunction

   task automatic drive(input bit w8, input logic rdy, input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
      if (w8) begin
         b8.ready_in = rdy;
         b8.base_in = b[7:0];
         b8.exponent_in = e[7:0];
         b8.modulus_in = m[7:0];
      end else begin
         b16.ready_in = rdy;
         b16.base_in = b;
         b16.exponent_in = e;
         b16.modulus_in = m;
      end
   endtask

   task automatic run_job(input bit w8, input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                          input logic [15:0] want, input int n, input bit toggle, input string name);
      int k;
      bit seen;
      @(negedge clk);
      drive(w8, 1'b1, b, e, m);
      @(posedge clk);
      #1;
      drive(w8, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
      total++;
      if (bsy(w8) !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", name, bsy(w8));
      else passed++;
      k = 0;
      seen = 1'b0;
      while (!seen && k < n + 20) begin
         if (toggle) drive(w8, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
         @(posedge clk);
         #1;
         k++;
         seen = vld(w8) === 1'b1;
      end
      drive(w8, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
      total++;
      if (k !== n + 1) $display("FAIL %s latency: got %0d edges want %0d", name, k, n + 1);
      else passed++;
      total++;
      if (res(w8) !== want) $display("FAIL %s result: got %0d want %0d", name, res(w8), want);
      else passed++;
      total++;
      if (erro(w8) !== (m == 0)) $display("FAIL %s error: got %b want %b", name, erro(w8), m == 0);
      else passed++;
      total++;
      if (bsy(w8) !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", name, bsy(w8));
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (vld(w8) !== 1'b0 || erro(w8) !== 1'b0) $display("FAIL %s pulse_width: valid %b error %b want 0 0", name, vld(w8), erro(w8));
      else passed++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
      drive(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({b16.result_out, b16.busy_out, b16.valid_out, b16.error_out} !== 19'd0)
         $display("FAIL reset16: got %h want 0", {b16.result_out, b16.busy_out, b16.valid_out, b16.error_out});
      else passed++;
      total++;
      if ({b8.result_out, b8.busy_out, b8.valid_out, b8.error_out} !== 11'd0)
         $display("FAIL reset8: got %h want 0", {b8.result_out, b8.busy_out, b8.valid_out, b8.error_out});
      else passed++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
`ifdef MOD_EXP_CONSTANT_TIME_EN
      run_job(1'b0, 16'd4, 16'd13, 16'd497, 16'd445, 528, 1'b0, "basic");
`else
      run_job(1'b0, 16'd4, 16'd13, 16'd497, 16'd445, 320, 1'b0, "basic");
`endif
   endtask

   task automatic test_abort_reset;
      bit early;
      early = 1'b0;
      @(negedge clk);
      drive(1'b0, 1'b1, 16'd4, 16'd13, 16'd497);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
      repeat (50) begin
         @(posedge clk);
         #1;
         if (b16.valid_out === 1'b1) early = 1'b1;
      end
      #1;
      rst = 1'b1;
      #1;
      total++;
      if ({b16.result_out, b16.busy_out, b16.valid_out, b16.error_out} !== 19'd0 || early)
         $display("FAIL abort_reset: outputs %h early_valid %b want 0 0", {b16.result_out, b16.busy_out, b16.valid_out, b16.error_out}, early);
      else passed++;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (b16.valid_out === 1'b1) early = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (400) begin
         @(posedge clk);
         #1;
         if (b16.valid_out === 1'b1) early = 1'b1;
      end
      total++;
      if (early) $display("FAIL abort_no_valid: got valid 1 want 0");
      else passed++;
      run_job(1'b0, 16'd3, 16'd5, 16'd7, 16'd5, lat(16, 16'd5, 16'd7), 1'b0, "restart");
   endtask

   task automatic test_unreduced;
      run_job(1'b0, 16'd1000, 16'd2, 16'd7, 16'd1, lat(16, 16'd2, 16'd7), 1'b0, "unreduced");
      run_job(1'b0, 16'd1000, 16'd0, 16'd7, 16'd1, lat(16, 16'd0, 16'd7), 1'b0, "exp_zero");
      run_job(1'b0, 16'd9, 16'd5, 16'd1, 16'd0, lat(16, 16'd5, 16'd1), 1'b0, "mod_one");
   endtask

   task automatic test_full_width;
      run_job(1'b1, 16'd255, 16'd255, 16'd251, 16'd20, 136, 1'b0, "full_width8");
   endtask

   task automatic test_error;
      run_job(1'b0, 16'd5, 16'd3, 16'd0, 16'd0, 0, 1'b0, "error16");
      run_job(1'b1, 16'd5, 16'd3, 16'd0, 16'd0, 0, 1'b1, "error8");
   endtask

   task automatic test_ignored_start;
`ifdef MOD_EXP_CONSTANT_TIME_EN
      run_job(1'b0, 16'd4, 16'd13, 16'd497, 16'd445, 528, 1'b1, "ignored_start");
`else
      run_job(1'b0, 16'd4, 16'd13, 16'd497, 16'd445, 320, 1'b1, "ignored_start");
`endif
   endtask

   task automatic test_random;
      logic [15:0] b, e, m;
      for (int i = 0; i < 12; i++) begin
         bit w8;
         w8 = i[0];
         b = 16'($urandom);
         e = 16'($urandom);
         m = $urandom_range(0, 2) == 0 ? 16'($urandom_range(0, 5)) : 16'($urandom);
         if (w8) begin
            b = {8'h00, b[7:0]};
            e = {8'h00, e[7:0]};
            m = {8'h00, m[7:0]};
         end
         run_job(w8, b, e, m, ref_exp(b, e, m), lat(w8 ? 8 : 16, e, m), i % 3 == 0, w8 ? "random8" : "random16");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_abort_reset();
      test_unreduced();
      test_full_width();
      test_error();
      test_ignored_start();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
